// File: rtl/prco_mem_stage_pkg.sv
// rtl/prco_mem_stage_pkg.sv - shared types and constants for the memory stage
package prco_mem_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    localparam logic [15:0] PRCO_MEM_TIMEOUT_DEFAULT = 16'd255;

    localparam logic [4:0] PRCO_OP_ADD = 5'h00;
    localparam logic [4:0] PRCO_OP_LW  = 5'h10;
    localparam logic [4:0] PRCO_OP_SW  = 5'h11;

    function automatic logic is_mem_op(input logic [4:0] op);
        return (op == PRCO_OP_LW) || (op == PRCO_OP_SW);
    endfunction

endpackage

// File: rtl/prco_mem_stage_if.sv
// rtl/prco_mem_stage_if.sv - RAM request/completion port of the memory stage
interface prco_mem_stage_if;
    logic        q_mem_req;
    logic        q_mem_we;
    logic [15:0] q_mem_addr;
    logic [15:0] q_mem_wdata;
    logic        i_mem_ack;
    logic [15:0] i_mem_rdata;

    modport master (
        output q_mem_req, q_mem_we, q_mem_addr, q_mem_wdata,
        input  i_mem_ack, i_mem_rdata
    );

    modport slave (
        input  q_mem_req, q_mem_we, q_mem_addr, q_mem_wdata,
        output i_mem_ack, i_mem_rdata
    );
endinterface

// File: rtl/prco_mem_timer.sv
// rtl/prco_mem_timer.sv - REQ-state wait counter, flags expiry on the last allowed cycle
module prco_mem_timer
    import prco_mem_stage_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = PRCO_MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [15:0] count;

    // expired is asserted during the TIMEOUT_CYCLES-th counted cycle so the
    // FSM leaves REQ at the end of exactly that many cycles
    assign expired = ({1'b0, count} + 17'd1) >= {1'b0, TIMEOUT_CYCLES};

    // count REQ cycles without ack; saturate once expired
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 16'd0;
        end else if (clear) begin
            count <= 16'd0;
        end else if (enable && !expired) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/prco_mem_stage.sv
// rtl/prco_mem_stage.sv - LW/SW memory stage FSM; optional timeout under PRCO_MEM_TIMEOUT_EN
module prco_mem_stage
    import prco_mem_stage_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = PRCO_MEM_TIMEOUT_DEFAULT
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_ce,
    input  logic [4:0]             i_op,
    input  logic [15:0]            i_addr,
    input  logic [15:0]            i_wdata,
    input  logic [2:0]             i_rd,
    output logic                   q_busy,
    output logic                   q_ce_reg,
    output logic                   q_reg_we,
    output logic [2:0]             q_rd,
    output logic [15:0]            q_rdata,
    output logic                   q_fault,
    prco_mem_stage_if.master       mem
);

    mem_state_t  state_q, state_d;
    logic        accept;
    logic        take_ack;
    logic        time_out;
    logic        timer_expired;
    logic        abort_q;

    logic        op_lw_q;
    logic        op_sw_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [2:0]  rd_q;
    logic [15:0] rdata_q;

    // state register; reset abandons any transaction in flight
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state and transaction strobes; ack outranks a same-cycle timeout
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        take_ack = 1'b0;
        time_out = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_ce) begin
                    accept  = 1'b1;
                    state_d = is_mem_op(i_op) ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (mem.i_mem_ack) begin
                    take_ack = 1'b1;
                    state_d  = ST_DONE;
                end else if (timer_expired) begin
                    time_out = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // latch the request on accept; load read data only for LW on ack
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            op_lw_q <= 1'b0;
            op_sw_q <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
            rd_q    <= 3'd0;
            rdata_q <= 16'd0;
        end else if (accept) begin
            op_lw_q <= (i_op == PRCO_OP_LW);
            op_sw_q <= (i_op == PRCO_OP_SW);
            addr_q  <= i_addr;
            wdata_q <= i_wdata;
            rd_q    <= i_rd;
            rdata_q <= 16'd0;
        end else if (take_ack && op_lw_q) begin
            rdata_q <= mem.i_mem_rdata;
        end
    end

`ifdef PRCO_MEM_TIMEOUT_EN
    logic fault_q;

    prco_mem_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (i_clk),
        .reset  (i_reset),
        .clear  (accept),
        .enable (state_q == ST_REQ && !mem.i_mem_ack),
        .expired(timer_expired)
    );

    // sticky fault plus a per-transaction abort that suppresses writeback
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            fault_q <= 1'b0;
            abort_q <= 1'b0;
        end else if (time_out) begin
            fault_q <= 1'b1;
            abort_q <= 1'b1;
        end else if (accept) begin
            abort_q <= 1'b0;
        end
    end

    assign q_fault = fault_q;
`else
    logic unused_timeout;

    assign unused_timeout = ^{TIMEOUT_CYCLES, time_out};
    assign timer_expired  = 1'b0;
    assign abort_q        = 1'b0;
    assign q_fault        = 1'b0;
`endif

    assign q_busy          = (state_q != ST_IDLE);
    assign q_ce_reg        = (state_q == ST_DONE);
    assign q_reg_we        = (state_q == ST_DONE) && op_lw_q && !abort_q;
    assign q_rd            = rd_q;
    assign q_rdata         = rdata_q;
    assign mem.q_mem_req   = (state_q == ST_REQ);
    assign mem.q_mem_we    = (state_q == ST_REQ) && op_sw_q;
    assign mem.q_mem_addr  = addr_q;
    assign mem.q_mem_wdata = wdata_q;

endmodule
